// File: rtl/aha_clk_select_sequencer.sv
// ---------------------------------------------------------------------------
// aha_clk_select_sequencer
//
// Glitch-safe clock-switch sequencer for one switchable clock domain. It sits
// in front of the platform clock controller and owns that domain's
// *_CLK_SELECT / *_CLK_GATE inputs. A request carries a new divider select
// and a final gate state. The block waits for the peripheral to go idle,
// gates the clock, holds, switches the select, settles, then restores the
// requested gate state. The select only ever moves while the clock is gated.
//
// Ports
//   CLK          in   free-running system clock
//   RESET        in   asynchronous, active-high reset
//   REQ_VALID    in   request strobe
//   REQ_SELECT   in   [2:0] requested divider select, 0..5 = /1../32
//   REQ_GATE     in   requested final gate state, 1 = clock stopped
//   REQ_READY    out  request accepted when REQ_VALID & REQ_READY at an edge
//   PERIPH_IDLE  in   domain is quiescent and may be gated
//   CLK_SELECT   out  [2:0] to the clock controller select input
//   CLK_GATE     out  to the clock controller gate input
//   BUSY         out  sequencer is not idle (always the inverse of REQ_READY)
//   DONE         out  one-cycle pulse, request completed
//   ERR          out  one-cycle pulse, request rejected or timed out
//
// State table
//   state       | meaning
//   ------------+------------------------------------------------------------
//   IDLE        | ready for a request; trivial requests complete here
//   WAIT_IDLE   | waiting (bounded) for PERIPH_IDLE before gating the clock
//   GATED       | clock gated, holding GATE_DLY cycles before the switch
//   SWITCHED    | new select applied, settling SWITCH_DLY cycles
// ---------------------------------------------------------------------------
module aha_clk_select_sequencer #(
  parameter int unsigned GATE_DLY     = 4,
  parameter int unsigned SWITCH_DLY   = 8,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter logic [2:0]  RESET_SELECT = 3'd1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_SELECT,
  input  logic       REQ_GATE,
  output logic       REQ_READY,
  input  logic       PERIPH_IDLE,
  output logic [2:0] CLK_SELECT,
  output logic       CLK_GATE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_GATED     = 2'd2,
    ST_SWITCHED  = 2'd3
  } state_t;

  localparam logic [9:0] GATE_LOAD    = 10'(GATE_DLY - 1);
  localparam logic [9:0] SWITCH_LOAD  = 10'(SWITCH_DLY - 1);
  localparam logic [9:0] TIMEOUT_LAST = 10'(IDLE_TIMEOUT - 1);
  localparam logic [2:0] SELECT_MAX   = 3'd5;

  state_t     state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic [2:0] sel_q, sel_q_nxt;
  logic       gate_q, gate_q_nxt;
  logic [2:0] clk_select_nxt;
  logic       clk_gate_nxt;
  logic       done_nxt;
  logic       err_nxt;
  logic       ready_nxt;
  logic       accept;

  // REQ_READY is a registered copy of "state is IDLE", so an accept can only
  // happen while the FSM is idle; requests presented while busy are dropped.
  assign accept = REQ_VALID && REQ_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel_q      <= RESET_SELECT;
      gate_q     <= 1'b0;
      CLK_SELECT <= RESET_SELECT;
      CLK_GATE   <= 1'b0;
      REQ_READY  <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_q      <= sel_q_nxt;
      gate_q     <= gate_q_nxt;
      CLK_SELECT <= clk_select_nxt;
      CLK_GATE   <= clk_gate_nxt;
      REQ_READY  <= ready_nxt;
      BUSY       <= !ready_nxt;
      DONE       <= done_nxt;
      ERR        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_q_nxt      = sel_q;
    gate_q_nxt     = gate_q;
    clk_select_nxt = CLK_SELECT;
    clk_gate_nxt   = CLK_GATE;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          sel_q_nxt  = REQ_SELECT;
          gate_q_nxt = REQ_GATE;
          if (REQ_SELECT > SELECT_MAX) begin
            err_nxt = 1'b1;
          end else if (REQ_SELECT == CLK_SELECT && REQ_GATE == CLK_GATE) begin
            done_nxt = 1'b1;
          end else if (REQ_SELECT == CLK_SELECT && !REQ_GATE) begin
            // Releasing the gate cannot disturb a busy peripheral, so no
            // idle handshake is needed.
            clk_gate_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            state_nxt = ST_WAIT_IDLE;
            cnt_nxt   = '0;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (PERIPH_IDLE) begin
          clk_gate_nxt = 1'b1;
          if (sel_q != CLK_SELECT) begin
            state_nxt = ST_GATED;
            cnt_nxt   = GATE_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end

      ST_GATED: begin
        if (cnt == '0) begin
          clk_select_nxt = sel_q;
          cnt_nxt        = SWITCH_LOAD;
          state_nxt      = ST_SWITCHED;
        end else begin
          cnt_nxt = cnt - 10'd1;
        end
      end

      ST_SWITCHED: begin
        if (cnt == '0) begin
          clk_gate_nxt = gate_q;
          done_nxt     = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 10'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
  end

  // Invariants of the sequencing; they hold for every legal parameter set.
  a_select_only_while_gated: assert property (@(posedge CLK) disable iff (RESET)
    (CLK_SELECT != $past(CLK_SELECT)) |-> (CLK_GATE && $past(CLK_GATE)));

  a_done_err_exclusive: assert property (@(posedge CLK) disable iff (RESET)
    !(DONE && ERR));

  a_busy_is_not_ready: assert property (@(posedge CLK) disable iff (RESET)
    BUSY == !REQ_READY);

endmodule

// File: tb/tb_aha_clk_select_sequencer.sv
module tb_aha_clk_select_sequencer;

  localparam int         GATE_DLY     = 4;
  localparam int         SWITCH_DLY   = 8;
  localparam int         IDLE_TIMEOUT = 64;
  localparam logic [2:0] RESET_SELECT = 3'd1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic [2:0] REQ_SELECT = 3'd0;
  logic       REQ_GATE = 1'b0;
  logic       REQ_READY;
  logic       PERIPH_IDLE = 1'b0;
  logic [2:0] CLK_SELECT;
  logic       CLK_GATE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  aha_clk_select_sequencer #(
    .GATE_DLY    (GATE_DLY),
    .SWITCH_DLY  (SWITCH_DLY),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .RESET_SELECT(RESET_SELECT)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ_VALID  (REQ_VALID),
    .REQ_SELECT (REQ_SELECT),
    .REQ_GATE   (REQ_GATE),
    .REQ_READY  (REQ_READY),
    .PERIPH_IDLE(PERIPH_IDLE),
    .CLK_SELECT (CLK_SELECT),
    .CLK_GATE   (CLK_GATE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_err;
    logic [2:0] sel;
    logic       gate;
    int         lat;       // accept edge to completion, 1 = next cycle
    int         gate_lat;  // -1 when no gate rise is expected
    int         sel_lat;   // -1 when no select change is expected
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         e0 = 0;
  int         lat_gate = -1;
  int         lat_sel = -1;
  logic [2:0] prev_sel;
  logic       prev_gate;
  logic [2:0] msel;
  logic       mgate;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on DONE/ERR.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_sel  = CLK_SELECT;
      prev_gate = CLK_GATE;
      lat_gate  = -1;
      lat_sel   = -1;
    end else begin
      check("busy_vs_ready", BUSY, !REQ_READY);
      check("done_err_overlap", DONE && ERR, 0);
      if (CLK_SELECT !== prev_sel) begin
        check("gated_at_switch", prev_gate && CLK_GATE, 1);
        lat_sel = cyc - e0 + 1;
      end
      if (CLK_GATE && !prev_gate) lat_gate = cyc - e0 + 1;
      if (DONE || ERR) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion actual done=%0b err=%0b required none", DONE, ERR);
        end else begin
          mon_e = sb.pop_front();
          check("completion_is_err", ERR, mon_e.is_err);
          check("final_select", CLK_SELECT, mon_e.sel);
          check("final_gate", CLK_GATE, mon_e.gate);
          check("completion_latency", cyc - e0 + 1, mon_e.lat);
          if (mon_e.gate_lat >= 0) check("gate_rise_latency", lat_gate, mon_e.gate_lat);
          if (mon_e.sel_lat >= 0) check("select_change_latency", lat_sel, mon_e.sel_lat);
          lat_gate = -1;
          lat_sel  = -1;
        end
      end
      prev_sel  = CLK_SELECT;
      prev_gate = CLK_GATE;
    end
  end

  // k = number of sampled WAIT_IDLE cycles with PERIPH_IDLE low.
  // mode 0: plain, 1: inject a request while GATED, 2: reset during SWITCHED.
  task automatic do_req(input logic [2:0] sel, input logic gate, input int k, input int mode);
    exp_t e;
    bit   busy_exp;
    int   n;
    @(negedge CLK);
    REQ_SELECT  = sel;
    REQ_GATE    = gate;
    REQ_VALID   = 1'b1;
    PERIPH_IDLE = (k == 0);
    check("ready_before_accept", REQ_READY, 1);
    @(posedge CLK);
    #1;
    e0        = cyc;
    REQ_VALID = 1'b0;

    e.is_err   = 1'b0;
    e.gate_lat = -1;
    e.sel_lat  = -1;
    e.lat      = 1;
    busy_exp   = 1'b0;
    if (sel > 3'd5) begin
      e.is_err = 1'b1;
    end else if (sel == msel && gate == mgate) begin
      e.lat = 1;
    end else if (sel == msel && !gate) begin
      mgate = 1'b0;
    end else begin
      busy_exp = 1'b1;
      if (k >= IDLE_TIMEOUT) begin
        e.is_err = 1'b1;
        e.lat    = IDLE_TIMEOUT + 1;
      end else if (sel == msel) begin
        e.lat      = k + 2;
        e.gate_lat = k + 2;
        mgate      = 1'b1;
      end else begin
        e.lat     = k + 2 + GATE_DLY + SWITCH_DLY;
        e.sel_lat = k + 2 + GATE_DLY;
        if (!mgate) e.gate_lat = k + 2;
        msel  = sel;
        mgate = gate;
      end
    end
    e.sel  = msel;
    e.gate = mgate;
    sb.push_back(e);
    check("busy_after_accept", BUSY, busy_exp);

    if (k > 0) begin
      repeat (k) @(posedge CLK);
      #1;
      PERIPH_IDLE = 1'b1;
    end

    if (mode == 1) begin
      repeat (3) @(negedge CLK);
      REQ_SELECT = 3'd5;
      REQ_GATE   = 1'b0;
      REQ_VALID  = 1'b1;
      check("ready_low_while_gated", REQ_READY, 0);
      check("busy_while_gated", BUSY, 1);
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
    end

    if (mode == 2) begin
      repeat (8) @(negedge CLK);
      check("select_in_switched", CLK_SELECT, sel);
      check("busy_in_switched", BUSY, 1);
      #2;
      RESET = 1'b1;
      #1;
      check("async_reset_select", CLK_SELECT, RESET_SELECT);
      check("async_reset_gate", CLK_GATE, 0);
      check("async_reset_ready", REQ_READY, 1);
      check("async_reset_busy", BUSY, 0);
      sb.delete();
      msel  = RESET_SELECT;
      mgate = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (25) @(negedge CLK);
    end else begin
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
        @(negedge CLK);
        n++;
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL completion_timeout actual pending=%0d required 0", sb.size());
        sb.delete();
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    msel  = RESET_SELECT;
    mgate = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_select", CLK_SELECT, RESET_SELECT);
    check("reset_gate", CLK_GATE, 0);
    check("reset_ready", REQ_READY, 1);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_err", ERR, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    do_req(3'd3, 1'b0, 0, 0);     // select change, 14-cycle sequence
    do_req(3'd2, 1'b0, 100, 0);   // idle never comes: timeout
    do_req(3'd2, 1'b0, 10, 0);    // idle after 10 cycles
    do_req(3'd4, 1'b0, 63, 0);    // last sample before timeout
    do_req(3'd5, 1'b0, 64, 0);    // exactly at timeout
    do_req(3'd7, 1'b0, 0, 0);     // illegal select
    do_req(3'd6, 1'b1, 0, 0);     // illegal select
    do_req(3'd1, 1'b0, 0, 0);
    do_req(3'd1, 1'b1, 0, 0);     // gate only
    do_req(3'd1, 1'b0, 0, 0);     // ungate only
    do_req(3'd3, 1'b0, 0, 1);     // request ignored while GATED
    do_req(3'd3, 1'b0, 0, 0);     // no-op
    do_req(3'd0, 1'b1, 2, 0);     // switch and stay gated
    do_req(3'd2, 1'b0, 0, 0);     // switch from gated state

    for (int i = 0; i < 40; i++) begin
      logic [2:0] rs;
      logic       rg;
      int         rk;
      rs = 3'($urandom_range(0, 7));
      rg = 1'($urandom_range(0, 1));
      rk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 4));
      do_req(rs, rg, rk, 0);
    end

    do_req(3'd0, 1'b0, 0, 0);
    do_req(3'd3, 1'b0, 0, 2);     // reset during SWITCHED
    do_req(3'd4, 1'b0, 0, 0);     // operates normally after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
